// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard, forwarding and sequencing controller for an in-order
//               core with a configurable number of post-decode stages. Keeps
//               a shadow pipeline of register tags and derives stalls,
//               flushes, forwarding selects and the execute hold from it.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int NUM_STAGES = 3,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 32,
    parameter int FW         = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_d,
    input  logic [REG_AW-1:0]     rs1_d,
    input  logic [REG_AW-1:0]     rs2_d,
    input  logic [REG_AW-1:0]     rd_d,
    input  logic                  regwrite_d,
    input  logic                  is_load_d,
    input  logic                  redirect_e,
    input  logic                  ex_busy_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  hold_e,
    output logic [FW-1:0]         fwd_a_e,
    output logic [FW-1:0]         fwd_b_e,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // Shadow pipeline, index 0 = Execute
    logic [NUM_STAGES-1:0] r_valid;
    logic [REG_AW-1:0]     r_rs1      [NUM_STAGES];
    logic [REG_AW-1:0]     r_rs2      [NUM_STAGES];
    logic [REG_AW-1:0]     r_rd       [NUM_STAGES];
    logic                  r_regwrite [NUM_STAGES];
    logic                  r_is_load  [NUM_STAGES];
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_flush_cnt;

    logic [NUM_STAGES-1:0] w_writer;
    logic                  w_busy;
    logic                  w_redir;
    logic                  w_lu;
    logic                  w_lu_stall;
    logic [FW-1:0]         w_fwd_a;
    logic [FW-1:0]         w_fwd_b;

    // An entry produces a register result only if valid, writing and rd != x0
    genvar gk;
    generate
        for (gk = 0; gk < NUM_STAGES; gk++) begin : g_writer
            assign w_writer[gk] = r_valid[gk] & r_regwrite[gk] & (r_rd[gk] != '0);
        end
    endgenerate

    // Busy and redirect only mean something when Execute holds a real
    // instruction; this also makes all outputs zero right after reset.
    assign w_busy  = r_valid[0] & ex_busy_e;
    assign w_redir = r_valid[0] & redirect_e & ~ex_busy_e;
    assign w_lu    = valid_d & w_writer[0] & r_is_load[0] &
                     (((rs1_d != '0) && (rs1_d == r_rd[0])) ||
                      ((rs2_d != '0) && (rs2_d == r_rd[0])));
    assign w_lu_stall = w_lu & ~w_busy & ~w_redir;

    assign stall_f = w_busy | w_lu_stall;
    assign stall_d = w_busy | w_lu_stall;
    assign flush_d = w_redir;
    assign flush_e = w_redir | w_lu_stall;
    assign hold_e  = w_busy;

    // Forward select: scan oldest to youngest so the youngest producer wins
    always_comb begin
        w_fwd_a = '0;
        w_fwd_b = '0;
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (w_writer[k] && (r_rs1[0] != '0) && (r_rd[k] == r_rs1[0]))
                w_fwd_a = FW'(k);
            if (w_writer[k] && (r_rs2[0] != '0) && (r_rd[k] == r_rs2[0]))
                w_fwd_b = FW'(k);
        end
        if (!r_valid[0]) begin
            w_fwd_a = '0;
            w_fwd_b = '0;
        end
    end

    assign fwd_a_e     = w_fwd_a;
    assign fwd_b_e     = w_fwd_b;
    assign stage_valid = r_valid;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

    // Advance the shadow pipeline and the saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_rs1[k]      <= '0;
                r_rs2[k]      <= '0;
                r_rd[k]       <= '0;
                r_regwrite[k] <= 1'b0;
                r_is_load[k]  <= 1'b0;
            end
        end else begin
            // Stages 2 and up always advance; the last entry retires
            for (int k = 2; k < NUM_STAGES; k++) begin
                r_valid[k]    <= r_valid[k-1];
                r_rs1[k]      <= r_rs1[k-1];
                r_rs2[k]      <= r_rs2[k-1];
                r_rd[k]       <= r_rd[k-1];
                r_regwrite[k] <= r_regwrite[k-1];
                r_is_load[k]  <= r_is_load[k-1];
            end
            if (w_busy) begin
                // Execute holds its instruction, a bubble leaves behind it
                r_valid[1] <= 1'b0;
            end else begin
                r_valid[1]    <= r_valid[0];
                r_rs1[1]      <= r_rs1[0];
                r_rs2[1]      <= r_rs2[0];
                r_rd[1]       <= r_rd[0];
                r_regwrite[1] <= r_regwrite[0];
                r_is_load[1]  <= r_is_load[0];
                if (w_redir || w_lu_stall) begin
                    r_valid[0] <= 1'b0;
                end else begin
                    r_valid[0]    <= valid_d;
                    r_rs1[0]      <= rs1_d;
                    r_rs2[0]      <= rs2_d;
                    r_rd[0]       <= rd_d;
                    r_regwrite[0] <= regwrite_d;
                    r_is_load[0]  <= is_load_d;
                end
            end
            if (stall_f && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (flush_d && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. Two instances
//               (3 stages / 32-bit counters and 5 stages / 4-bit counters)
//               share the same stimulus and are compared every cycle against
//               a list-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, valid_d, regwrite_d, is_load_d, redirect_e, ex_busy_e;
    logic [4:0] rs1_d, rs2_d, rd_d;

    logic       a_stall_f, a_stall_d, a_flush_d, a_flush_e, a_hold_e;
    logic [1:0] a_fwd_a, a_fwd_b;
    logic [2:0] a_sv;
    logic [31:0] a_scnt, a_fcnt;

    logic       b_stall_f, b_stall_d, b_flush_d, b_flush_e, b_hold_e;
    logic [2:0] b_fwd_a, b_fwd_b;
    logic [4:0] b_sv;
    logic [3:0] b_scnt, b_fcnt;

    pipeline_hazard_ctrl #(.NUM_STAGES(3), .REG_AW(5), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_d(rd_d), .regwrite_d(regwrite_d), .is_load_d(is_load_d),
        .redirect_e(redirect_e), .ex_busy_e(ex_busy_e),
        .stall_f(a_stall_f), .stall_d(a_stall_d), .flush_d(a_flush_d),
        .flush_e(a_flush_e), .hold_e(a_hold_e), .fwd_a_e(a_fwd_a),
        .fwd_b_e(a_fwd_b), .stage_valid(a_sv), .stall_cnt(a_scnt),
        .flush_cnt(a_fcnt)
    );

    pipeline_hazard_ctrl #(.NUM_STAGES(5), .REG_AW(5), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_d(rd_d), .regwrite_d(regwrite_d), .is_load_d(is_load_d),
        .redirect_e(redirect_e), .ex_busy_e(ex_busy_e),
        .stall_f(b_stall_f), .stall_d(b_stall_d), .flush_d(b_flush_d),
        .flush_e(b_flush_e), .hold_e(b_hold_e), .fwd_a_e(b_fwd_a),
        .fwd_b_e(b_fwd_b), .stage_valid(b_sv), .stall_cnt(b_scnt),
        .flush_cnt(b_fcnt)
    );

    // Reference model: each pipeline is an ordered list of instructions,
    // position 0 = Execute; inserting at a position pushes older ones along
    // and drops whatever falls off the end.
    typedef struct {
        bit       v;
        bit [4:0] rs1;
        bit [4:0] rs2;
        bit [4:0] rd;
        bit       rw;
        bit       ld;
    } ent_t;

    ent_t            pipe [2][5];
    int              ns   [2];
    longint unsigned cmax [2];
    longint unsigned scnt [2];
    longint unsigned fcnt [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit produces(int m, int k);
        return pipe[m][k].v && pipe[m][k].rw && (pipe[m][k].rd != 5'd0);
    endfunction

    // Nearest stage (from Execute outward) that produces src, else 0
    function automatic int fwd_sel(int m, bit [4:0] src);
        if (!pipe[m][0].v || src == 5'd0) return 0;
        for (int k = 1; k < ns[m]; k++)
            if (produces(m, k) && pipe[m][k].rd == src) return k;
        return 0;
    endfunction

    // Which rule wins this cycle: 1 busy, 2 redirect, 3 load-use, 0 normal
    function automatic int rule(int m);
        bit lu;
        if (pipe[m][0].v && ex_busy_e === 1'b1) return 1;
        if (pipe[m][0].v && redirect_e === 1'b1) return 2;
        lu = valid_d && produces(m, 0) && pipe[m][0].ld &&
             ((rs1_d != 0 && rs1_d == pipe[m][0].rd) ||
              (rs2_d != 0 && rs2_d == pipe[m][0].rd));
        return lu ? 3 : 0;
    endfunction

    task automatic insert_at(int m, int pos, ent_t e);
        for (int k = ns[m] - 1; k > pos; k--) pipe[m][k] = pipe[m][k-1];
        pipe[m][pos] = e;
    endtask

    task automatic check_dut(int m);
        int          r;
        logic [63:0] g [10];
        logic [63:0] sv;
        string       n;
        r = rule(m);
        n = (m == 0) ? "ns3" : "ns5";
        if (m == 0) begin
            g[0] = a_stall_f; g[1] = a_stall_d; g[2] = a_flush_d; g[3] = a_flush_e;
            g[4] = a_hold_e;  g[5] = a_fwd_a;   g[6] = a_fwd_b;   g[7] = a_sv;
            g[8] = a_scnt;    g[9] = a_fcnt;
        end else begin
            g[0] = b_stall_f; g[1] = b_stall_d; g[2] = b_flush_d; g[3] = b_flush_e;
            g[4] = b_hold_e;  g[5] = b_fwd_a;   g[6] = b_fwd_b;   g[7] = b_sv;
            g[8] = b_scnt;    g[9] = b_fcnt;
        end
        sv = '0;
        for (int k = 0; k < ns[m]; k++) sv[k] = pipe[m][k].v;
        chk({n, " stall_f"}, g[0], 64'(r == 1 || r == 3));
        chk({n, " stall_d"}, g[1], 64'(r == 1 || r == 3));
        chk({n, " flush_d"}, g[2], 64'(r == 2));
        chk({n, " flush_e"}, g[3], 64'(r == 2 || r == 3));
        chk({n, " hold_e"},  g[4], 64'(r == 1));
        chk({n, " fwd_a"},   g[5], 64'(fwd_sel(m, pipe[m][0].rs1)));
        chk({n, " fwd_b"},   g[6], 64'(fwd_sel(m, pipe[m][0].rs2)));
        chk({n, " stage_valid"}, g[7], sv);
        chk({n, " stall_cnt"}, g[8], 64'(scnt[m]));
        chk({n, " flush_cnt"}, g[9], 64'(fcnt[m]));
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 5; k++) pipe[m][k] = '{0, 0, 0, 0, 0, 0};
            scnt[m] = 0;
            fcnt[m] = 0;
        end
    endtask

    task automatic model_clock();
        int   r;
        ent_t bub;
        ent_t dec;
        bub = '{0, 0, 0, 0, 0, 0};
        dec = '{valid_d, rs1_d, rs2_d, rd_d, regwrite_d, is_load_d};
        for (int m = 0; m < 2; m++) begin
            r = rule(m);
            if ((r == 1 || r == 3) && scnt[m] < cmax[m]) scnt[m]++;
            if (r == 2 && fcnt[m] < cmax[m]) fcnt[m]++;
            case (r)
                1:       insert_at(m, 1, bub);
                2, 3:    insert_at(m, 0, bub);
                default: insert_at(m, 0, dec);
            endcase
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then advance
    task automatic step(input bit r, input bit vd, input int s1, input int s2,
                        input int d, input bit rw, input bit ld,
                        input bit red, input bit bsy);
        @(negedge clk);
        rst = r; valid_d = vd; rs1_d = 5'(s1); rs2_d = 5'(s2); rd_d = 5'(d);
        regwrite_d = rw; is_load_d = ld; redirect_e = red; ex_busy_e = bsy;
        #1;
        check_dut(0);
        check_dut(1);
        if (r) model_reset();
        else   model_clock();
    endtask

    initial begin
        bit busy_on;
        ns[0] = 3; ns[1] = 5;
        cmax[0] = 64'hFFFF_FFFF; cmax[1] = 15;
        rst = 1'b1; valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
        regwrite_d = 0; is_load_d = 0; redirect_e = 0; ex_busy_e = 0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, busy/redirect with nothing in Execute
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Back-to-back forwarding, second reader, write to x0
        step(0, 1, 1, 2, 5, 1, 0, 0, 0);
        step(0, 1, 5, 5, 6, 1, 0, 0, 0);
        step(0, 1, 5, 6, 0, 1, 0, 0, 0);
        step(0, 1, 0, 5, 8, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Load-use: one bubble, add presented again while stalled
        step(0, 1, 1, 1, 7, 1, 1, 0, 0);
        step(0, 1, 7, 7, 9, 1, 0, 0, 0);
        step(0, 1, 7, 7, 9, 1, 0, 0, 0);
        step(0, 1, 9, 7, 10, 1, 0, 0, 0);
        // Youngest producer of x3
        step(0, 1, 1, 1, 3, 1, 0, 0, 0);
        step(0, 1, 2, 2, 3, 1, 0, 0, 0);
        step(0, 1, 3, 3, 4, 1, 0, 0, 0);
        step(0, 1, 4, 3, 11, 1, 0, 0, 0);
        // Busy for four cycles with a redirect pulse inside
        step(0, 1, 1, 2, 12, 1, 0, 0, 1);
        step(0, 1, 1, 2, 12, 1, 0, 1, 1);
        step(0, 1, 1, 2, 12, 1, 0, 0, 1);
        step(0, 1, 1, 2, 12, 1, 0, 0, 1);
        step(0, 1, 1, 2, 12, 1, 0, 0, 0);
        // Redirect coinciding with load-use
        step(0, 1, 1, 1, 4, 1, 1, 0, 0);
        step(0, 1, 4, 4, 5, 1, 0, 1, 0);
        step(0, 1, 1, 1, 6, 1, 0, 0, 0);
        // Reset in the middle of busy
        step(0, 1, 1, 1, 6, 1, 0, 0, 1);
        step(1, 1, 1, 1, 6, 1, 0, 0, 1);
        step(0, 1, 6, 6, 6, 1, 1, 1, 1);

        // Randomized traffic over a small register set to force collisions
        busy_on = 0;
        for (int i = 0; i < 2000; i++) begin
            if (busy_on) busy_on = ($urandom_range(0, 9) < 7);
            else         busy_on = ($urandom_range(0, 19) == 0);
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 15) == 0, busy_on);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
